// File: rtl/eeprom_cmd_seq.sv
// Command sequencer for the M25AA010A SPI EEPROM: expands one host read/write
// request into WREN/WRITE/RDSR-poll or READ frames for the SPI byte engine.
module eeprom_cmd_seq #(
   parameter int unsigned CS_GAP   = 4,
   parameter int unsigned POLL_MAX = 50000
) (
   input  logic       clk_50M,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       eng_start,
   output logic [7:0] eng_data,
   input  logic       eng_done,
   input  logic [7:0] eng_rdata,
   output logic       eng_csn
);

   localparam logic [7:0]  OP_WREN  = 8'h06;
   localparam logic [7:0]  OP_WRITE = 8'h02;
   localparam logic [7:0]  OP_RDSR  = 8'h05;
   localparam logic [7:0]  OP_READ  = 8'h03;
   localparam logic [7:0]  DUMMY    = 8'h00;
   localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);
   localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_LO,
      ST_WAIT,
      ST_GAP,
      ST_DONE
   } state_e;

   typedef enum logic [3:0] {
      STP_WREN,
      STP_WR_INS,
      STP_WR_ADDR,
      STP_WR_DATA,
      STP_POLL_INS,
      STP_POLL_RD,
      STP_RD_INS,
      STP_RD_ADDR,
      STP_RD_DATA
   } step_e;

   state_e      state_q, state_d;
   step_e       step_q, step_d;
   logic [6:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [15:0] poll_cnt_q, poll_cnt_d;
   logic [15:0] gap_cnt_q, gap_cnt_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        eng_start_q, eng_start_d;
   logic [7:0]  eng_data_q, eng_data_d;
   logic        eng_csn_q, eng_csn_d;

   logic [15:0] poll_inc;
   logic        next_byte;

   function automatic logic [7:0] step_byte(input step_e s, input logic [6:0] a,
                                            input logic [7:0] wd);
      case (s)
         STP_WREN:     return OP_WREN;
         STP_WR_INS:   return OP_WRITE;
         STP_WR_ADDR:  return {1'b0, a};
         STP_WR_DATA:  return wd;
         STP_POLL_INS: return OP_RDSR;
         STP_RD_INS:   return OP_READ;
         STP_RD_ADDR:  return {1'b0, a};
         default:      return DUMMY;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      poll_cnt_d  = poll_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      eng_start_d = 1'b0;
      eng_data_d  = eng_data_q;
      eng_csn_d   = eng_csn_q;
      next_byte   = 1'b0;
      poll_inc    = (poll_cnt_q >= POLL_LIM) ? poll_cnt_q : poll_cnt_q + 16'd1;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d      = cmd_addr;
               wdata_d     = cmd_wdata;
               poll_cnt_d  = '0;
               step_d      = cmd_rw ? STP_WREN : STP_RD_INS;
               cmd_ready_d = 1'b0;
               eng_csn_d   = 1'b0;
               state_d     = ST_CS_LO;
            end
         end
         ST_CS_LO: begin
            eng_start_d = 1'b1;
            eng_data_d  = step_byte(step_q, addr_q, wdata_q);
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            if (eng_done) begin
               case (step_q)
                  STP_WREN: begin
                     eng_csn_d = 1'b1;
                     gap_cnt_d = '0;
                     step_d    = STP_WR_INS;
                     state_d   = ST_GAP;
                  end
                  STP_WR_INS: begin
                     step_d    = STP_WR_ADDR;
                     next_byte = 1'b1;
                  end
                  STP_WR_ADDR: begin
                     step_d    = STP_WR_DATA;
                     next_byte = 1'b1;
                  end
                  STP_WR_DATA: begin
                     eng_csn_d = 1'b1;
                     gap_cnt_d = '0;
                     step_d    = STP_POLL_INS;
                     state_d   = ST_GAP;
                  end
                  STP_POLL_INS: begin
                     step_d    = STP_POLL_RD;
                     next_byte = 1'b1;
                  end
                  STP_POLL_RD: begin
                     // WIP is only valid in this eng_done cycle, so the poll decision is made here
                     eng_csn_d  = 1'b1;
                     poll_cnt_d = poll_inc;
                     if (!eng_rdata[0]) begin
                        rsp_err_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_DONE;
                     end else if (poll_inc >= POLL_LIM) begin
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_DONE;
                     end else begin
                        gap_cnt_d = '0;
                        step_d    = STP_POLL_INS;
                        state_d   = ST_GAP;
                     end
                  end
                  STP_RD_INS: begin
                     step_d    = STP_RD_ADDR;
                     next_byte = 1'b1;
                  end
                  STP_RD_ADDR: begin
                     step_d    = STP_RD_DATA;
                     next_byte = 1'b1;
                  end
                  STP_RD_DATA: begin
                     eng_csn_d   = 1'b1;
                     rsp_rdata_d = eng_rdata;
                     rsp_err_d   = 1'b0;
                     rsp_valid_d = 1'b1;
                     state_d     = ST_DONE;
                  end
                  default: begin
                     eng_csn_d = 1'b1;
                     state_d   = ST_DONE;
                  end
               endcase
            end
         end
         ST_GAP: begin
            if (gap_cnt_q >= GAP_LAST) begin
               eng_csn_d = 1'b0;
               state_d   = ST_CS_LO;
            end else begin
               gap_cnt_d = gap_cnt_q + 16'd1;
            end
         end
         ST_DONE: begin
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: begin
            eng_csn_d   = 1'b1;
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase

      if (next_byte) begin
         eng_start_d = 1'b1;
         eng_data_d  = step_byte(step_d, addr_q, wdata_q);
      end
   end

   always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         step_q      <= STP_WREN;
         addr_q      <= '0;
         wdata_q     <= '0;
         poll_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         eng_start_q <= 1'b0;
         eng_data_q  <= '0;
         eng_csn_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         poll_cnt_q  <= poll_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         eng_start_q <= eng_start_d;
         eng_data_q  <= eng_data_d;
         eng_csn_q   <= eng_csn_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign eng_start = eng_start_q;
   assign eng_data  = eng_data_q;
   assign eng_csn   = eng_csn_q;

endmodule

// File: tb/tb_eeprom_cmd_seq.sv
// Bench for eeprom_cmd_seq: a byte-engine/EEPROM model plus a table of host
// transactions with hand-computed frames, and directed reset/spurious sequences.
module tb_eeprom_cmd_seq;

   localparam int unsigned GAP  = 4;
   localparam int unsigned PMAX = 3;
   localparam int unsigned LAT  = 3;

   logic       clk_50M = 1'b0;
   logic       reset   = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_rw = 1'b0;
   logic [6:0] cmd_addr = '0;
   logic [7:0] cmd_wdata = '0;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       eng_start;
   logic [7:0] eng_data;
   logic       eng_done;
   logic [7:0] eng_rdata;
   logic       eng_csn;

   eeprom_cmd_seq #(.CS_GAP(GAP), .POLL_MAX(PMAX)) dut (
      .clk_50M  (clk_50M),
      .reset    (reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_rw   (cmd_rw),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .eng_start(eng_start),
      .eng_data (eng_data),
      .eng_done (eng_done),
      .eng_rdata(eng_rdata),
      .eng_csn  (eng_csn)
   );

   always #10 clk_50M = ~clk_50M;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // engine / EEPROM model state
   int         busy_left = 0;
   logic [7:0] rd_val = '0;
   logic [7:0] tx_q[$];
   int         starts = 0;
   int         rsp_cnt = 0;
   int         txn_frames = 0;
   int         hi_run = 0;
   int         since_fall = 0;
   int         byte_idx = 0;
   int         lat = 0;
   logic       prev_csn = 1'b1;
   logic [7:0] frame_op = '0;
   logic [7:0] resp = '0;
   bit         spur_req = 1'b0;

   initial begin
      eng_done  = 1'b0;
      eng_rdata = '0;
      forever begin
         @(negedge clk_50M);
         if (!reset) begin
            eng_done  = 1'($urandom_range(0, 1));
            eng_rdata = 8'($urandom);
            lat       = 0;
            hi_run    = hi_run + 1;
            prev_csn  = eng_csn;
         end else begin
            eng_done = 1'b0;
            if (prev_csn && !eng_csn) begin
               if (txn_frames > 0) check("cs_gap_len", hi_run, GAP);
               txn_frames++;
               since_fall = 0;
               byte_idx   = 0;
            end else begin
               since_fall++;
            end
            hi_run = eng_csn ? hi_run + 1 : 0;
            if (lat > 0) begin
               lat--;
               if (lat == 0) begin
                  eng_done  = 1'b1;
                  eng_rdata = resp;
               end
            end
            if (eng_start) begin
               starts++;
               tx_q.push_back(eng_data);
               check("start_csn_low", eng_csn, 1'b0);
               if (byte_idx == 0) begin
                  check("csn_lead", since_fall, 1);
                  frame_op = eng_data;
               end
               resp = 8'hFF;
               if (frame_op == 8'h05 && byte_idx == 1) begin
                  if (busy_left > 0) begin
                     resp = 8'h01;
                     busy_left--;
                  end else begin
                     resp = 8'hFE;
                  end
               end
               if (frame_op == 8'h03 && byte_idx == 2) resp = rd_val;
               byte_idx++;
               lat = LAT;
            end
            if (!eng_done && spur_req) begin
               eng_done = 1'b1;
               spur_req = 1'b0;
            end
            if (rsp_valid) rsp_cnt++;
            prev_csn = eng_csn;
         end
      end
   end

   typedef struct {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
      int         busy;
      logic [7:0] rdv;
      int         hold;
      int         polls;
      int         frames;
      int         nbytes;
      logic [7:0] rdata;
      logic       err;
   } txn_t;

   txn_t tbl[6];

   task automatic run_txn(input int id, input txn_t t);
      logic [7:0] exp_q[$];
      int errs;
      bit got;
      busy_left  = t.busy;
      rd_val     = t.rdv;
      tx_q.delete();
      starts     = 0;
      rsp_cnt    = 0;
      txn_frames = 0;
      check($sformatf("t%0d_ready_idle", id), cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_rw    = t.rw;
      cmd_addr  = t.addr;
      cmd_wdata = t.wdata;
      @(negedge clk_50M);
      check($sformatf("t%0d_ready_drop", id), cmd_ready, 1'b0);
      repeat (t.hold) @(negedge clk_50M);
      cmd_valid = 1'b0;
      cmd_addr  = 7'($urandom);
      cmd_wdata = 8'($urandom);
      got = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk_50M);
         if (rsp_valid) got = 1'b1;
      end
      check($sformatf("t%0d_rsp_seen", id), got, 1'b1);
      if (got) begin
         check($sformatf("t%0d_rsp_err", id), rsp_err, t.err);
         if (!t.rw) check($sformatf("t%0d_rsp_rdata", id), rsp_rdata, t.rdata);
         check($sformatf("t%0d_csn_done", id), eng_csn, 1'b1);
         @(negedge clk_50M);
         check($sformatf("t%0d_ready_back", id), cmd_ready, 1'b1);
         check($sformatf("t%0d_rsp_pulse", id), rsp_valid, 1'b0);
      end
      repeat (6) @(negedge clk_50M);
      check($sformatf("t%0d_rsp_count", id), rsp_cnt, 1);
      check($sformatf("t%0d_frames", id), txn_frames, t.frames);
      check($sformatf("t%0d_starts", id), starts, t.nbytes);
      if (t.rw) begin
         exp_q = '{8'h06, 8'h02, {1'b0, t.addr}, t.wdata};
         for (int p = 0; p < t.polls; p++) begin
            exp_q.push_back(8'h05);
            exp_q.push_back(8'h00);
         end
      end else begin
         exp_q = '{8'h03, {1'b0, t.addr}, 8'h00};
      end
      errs = 0;
      if (tx_q.size() != exp_q.size()) errs = 1000;
      else foreach (exp_q[k]) if (tx_q[k] !== exp_q[k]) errs++;
      check($sformatf("t%0d_tx_byte_errs", id), errs, 0);
   endtask

   txn_t post;
   bit   hit;

   initial begin
      //           rw    addr   wdata  busy  rdv    hold pol frm byt rdata  err
      tbl[0] = '{1'b1, 7'h12, 8'hA5, 2,    8'h00, 0,   3,  5,  10, 8'h00, 1'b0};
      tbl[1] = '{1'b0, 7'h7F, 8'h00, 0,    8'h3C, 0,   0,  1,  3,  8'h3C, 1'b0};
      tbl[2] = '{1'b1, 7'h00, 8'hFF, 1000, 8'h00, 0,   3,  5,  10, 8'h00, 1'b1};
      tbl[3] = '{1'b1, 7'h55, 8'hC3, 0,    8'h00, 20,  1,  3,  6,  8'h00, 1'b0};
      tbl[4] = '{1'b0, 7'h00, 8'h00, 0,    8'h81, 0,   0,  1,  3,  8'h81, 1'b0};
      tbl[5] = '{1'b1, 7'h7F, 8'h5A, 1,    8'h00, 0,   2,  4,  8,  8'h00, 1'b0};
      post   = '{1'b0, 7'h2A, 8'h00, 0,    8'hE7, 0,   0,  1,  3,  8'hE7, 1'b0};

      // reset with random host inputs
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_50M);
         cmd_valid = 1'($urandom);
         cmd_rw    = 1'($urandom);
         cmd_addr  = 7'($urandom);
         cmd_wdata = 8'($urandom);
      end
      @(negedge clk_50M);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 8'h00);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_eng_start", eng_start, 1'b0);
      check("rst_eng_data", eng_data, 8'h00);
      check("rst_eng_csn", eng_csn, 1'b1);
      cmd_valid = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk_50M);

      foreach (tbl[i]) run_txn(i, tbl[i]);

      // spurious eng_done while idle
      starts  = 0;
      rsp_cnt = 0;
      spur_req = 1'b1;
      repeat (8) @(negedge clk_50M);
      check("spur_starts", starts, 0);
      check("spur_rsp", rsp_cnt, 0);
      check("spur_ready", cmd_ready, 1'b1);
      check("spur_csn", eng_csn, 1'b1);

      // reset while the write address byte is in flight
      busy_left = 0;
      tx_q.delete();
      txn_frames = 0;
      cmd_valid = 1'b1;
      cmd_rw    = 1'b1;
      cmd_addr  = 7'h33;
      cmd_wdata = 8'h44;
      @(negedge clk_50M);
      cmd_valid = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (tx_q.size() >= 3) hit = 1'b1;
         else @(negedge clk_50M);
      end
      check("mid_reached_wr_addr", hit, 1'b1);
      rsp_cnt = 0;
      #2 reset = 1'b0;
      #1;
      check("mid_csn_async", eng_csn, 1'b1);
      check("mid_ready_async", cmd_ready, 1'b1);
      check("mid_start_async", eng_start, 1'b0);
      repeat (3) @(negedge clk_50M);
      reset = 1'b1;
      repeat (20) @(negedge clk_50M);
      check("mid_no_rsp", rsp_cnt, 0);
      run_txn(9, post);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
